// File: rtl/am_pkg.sv
// Alignment-marker constants for the 40GBASE-R and 100GBASE-R marker sets, plus lock FSM encodings.
// Each marker value is {M2,M1,M0}, so M0 sits in bits [7:0]. M4..M6 are the bitwise inverse of M0..M2.
package am_pkg;

  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [2:0] ST_RESET_CNT = 3'd0;
  localparam logic [2:0] ST_FIND_1ST  = 3'd1;
  localparam logic [2:0] ST_COUNT_1   = 3'd2;
  localparam logic [2:0] ST_COMP_2ND  = 3'd3;
  localparam logic [2:0] ST_COUNT_2   = 3'd4;
  localparam logic [2:0] ST_COMP_AM   = 3'd5;
  localparam logic [2:0] ST_SLIP      = 3'd6;

  localparam logic [0:19][23:0] AM100_M012 = {
    24'h2168C1, 24'h8E719D, 24'hE84B59, 24'h7B954D,
    24'h0907F5, 24'hC214DD, 24'h264A9A, 24'h66457B,
    24'h7624A0, 24'hFBC968, 24'h996CFD, 24'h5591B9,
    24'hB2B95C, 24'hBDF81A, 24'hCAC783, 24'hCD3635,
    24'h4C31C4, 24'hB7D6AD, 24'h2A665F, 24'hE5F0C0
  };

  localparam logic [0:3][23:0] AM40_M012 = {
    24'h477690, 24'hE6C4F0, 24'h9B65C5, 24'h3D79A2
  };

  function automatic logic [23:0] am_m012(input int lane_n, input int lane);
    if (lane_n == 4) return AM40_M012[lane[1:0]];
    return AM100_M012[lane[4:0]];
  endfunction

  function automatic logic [23:0] am_m456(input int lane_n, input int lane);
    return ~am_m012(lane_n, lane);
  endfunction

endpackage

// File: rtl/am_bip3_calc.sv
// Combinational BIP3 contribution of one 66-bit block; the parent XORs it into its running accumulator.
// Bit j folds payload bits j+2+8k; bits 3 and 4 also fold in the two sync-header bits.
module am_bip3_calc #(
  parameter int BLOCK_W = 66
) (
  input  logic [BLOCK_W-1:0] block,
  output logic [7:0]         bip
);

  for (genvar j = 0; j < 8; j++) begin : g_bit
    logic [7:0] col;
    for (genvar k = 0; k < 8; k++) begin : g_col
      assign col[k] = block[j + 2 + 8 * k];
    end
    if (j == 3) begin : g_sync0
      assign bip[j] = (^col) ^ block[0];
    end else if (j == 4) begin : g_sync1
      assign bip[j] = (^col) ^ block[1];
    end else begin : g_plain
      assign bip[j] = ^col;
    end
  end

endmodule

// File: rtl/am_lock_multi_rx.sv
// Per-lane alignment-marker lock for 4-lane (40G) or 20-lane (100G) PCS receive, with BIP3 checking.
// A registered FSM judges each marker slot; every output changes one cycle after the deciding block.
module am_lock_multi_rx
  import am_pkg::*;
#(
  parameter int BLOCK_W     = 66,
  parameter int LANE_N      = 4,
  parameter int GAP_N       = 16383,
  parameter int INVALID_MAX = 4,
  parameter int BIP_EN      = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_i,
  input  logic                      signal_v_i,
  input  logic [BLOCK_W-1:0]        block_i,
  output logic                      lock_v_o,
  output logic                      slip_v_o,
  output logic                      am_v_o,
  output logic [LANE_N-1:0]         lane_o,
  output logic [$clog2(LANE_N)-1:0] lane_id_o,
  output logic                      bip_err_o
);

  localparam int LID_W = $clog2(LANE_N);
  localparam int CNT_W = $clog2(GAP_N + 1);
  localparam int INV_W = $clog2(INVALID_MAX + 1);

  if (LANE_N != 4 && LANE_N != 20) begin : g_bad_lane_n
    $error("am_lock_multi_rx: LANE_N must be 4 or 20");
  end

  logic [2:0]        state;
  logic [CNT_W-1:0]  gap_cnt;
  logic [INV_W-1:0]  inv_cnt;
  logic [LID_W-1:0]  cur_lane;
  logic [7:0]        bip_acc;
  logic [7:0]        blk_bip;
  logic [LANE_N-1:0] hit;
  logic [LID_W-1:0]  hit_id;
  logic              any_hit;
  logic              cur_hit;
  logic              gap_done;
  logic              inv_last;
  logic              bip_bad;

  // All lane comparators run in parallel; the marker sets guarantee at most one hit.
  for (genvar l = 0; l < LANE_N; l++) begin : g_lane
    localparam logic [23:0] M012 = am_m012(LANE_N, l);
    localparam logic [23:0] M456 = am_m456(LANE_N, l);
    assign hit[l] = (block_i[1:0] == SYNC_CTRL) &&
                    (block_i[25:2] == M012) &&
                    (block_i[57:34] == M456);
  end

  always_comb begin
    hit_id = '0;
    for (int l = 0; l < LANE_N; l++) begin
      if (hit[l]) hit_id = LID_W'(l);
    end
  end

  am_bip3_calc #(.BLOCK_W(BLOCK_W)) u_bip3 (
    .block (block_i),
    .bip   (blk_bip)
  );

  assign any_hit  = |hit;
  assign cur_hit  = hit[cur_lane];
  assign gap_done = (gap_cnt == CNT_W'(GAP_N - 1));
  assign inv_last = (inv_cnt == INV_W'(INVALID_MAX - 1));
  assign bip_bad  = (BIP_EN != 0) && (block_i[33:26] != bip_acc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RESET_CNT;
      gap_cnt   <= '0;
      inv_cnt   <= '0;
      cur_lane  <= '0;
      bip_acc   <= '0;
      lock_v_o  <= 1'b0;
      slip_v_o  <= 1'b0;
      am_v_o    <= 1'b0;
      bip_err_o <= 1'b0;
      lane_o    <= '0;
      lane_id_o <= '0;
    end else begin
      slip_v_o  <= 1'b0;
      am_v_o    <= 1'b0;
      bip_err_o <= 1'b0;
      if (!signal_v_i) begin
        // Losing the upstream block lock abandons the attempt silently: no slip pulse.
        state     <= ST_RESET_CNT;
        lock_v_o  <= 1'b0;
        lane_o    <= '0;
        lane_id_o <= '0;
      end else begin
        case (state)
          ST_RESET_CNT: begin
            gap_cnt <= '0;
            inv_cnt <= '0;
            bip_acc <= '0;
            state   <= ST_FIND_1ST;
          end
          // The block presented during SLIP is searched too, so no block is lost after a slip.
          ST_FIND_1ST, ST_SLIP: begin
            state <= ST_FIND_1ST;
            if (valid_i && any_hit) begin
              cur_lane <= hit_id;
              gap_cnt  <= '0;
              inv_cnt  <= '0;
              bip_acc  <= blk_bip;
              state    <= ST_COUNT_1;
            end
          end
          ST_COUNT_1, ST_COUNT_2: begin
            if (valid_i) begin
              bip_acc <= bip_acc ^ blk_bip;
              if (gap_done) begin
                gap_cnt <= CNT_W'(GAP_N);
                state   <= (state == ST_COUNT_1) ? ST_COMP_2ND : ST_COMP_AM;
              end else begin
                gap_cnt <= gap_cnt + 1'b1;
              end
            end
          end
          ST_COMP_2ND: begin
            if (valid_i) begin
              if (cur_hit) begin
                lock_v_o  <= 1'b1;
                lane_o    <= LANE_N'(1) << cur_lane;
                lane_id_o <= cur_lane;
                bip_err_o <= bip_bad;
                bip_acc   <= blk_bip;
                gap_cnt   <= '0;
                state     <= ST_COUNT_2;
              end else begin
                slip_v_o <= 1'b1;
                state    <= ST_SLIP;
              end
            end
          end
          ST_COMP_AM: begin
            if (valid_i) begin
              gap_cnt <= '0;
              if (cur_hit) begin
                am_v_o    <= 1'b1;
                bip_err_o <= bip_bad;
                bip_acc   <= blk_bip;
                inv_cnt   <= '0;
                state     <= ST_COUNT_2;
              end else begin
                // A missing marker is just another data block for BIP purposes.
                bip_acc <= bip_acc ^ blk_bip;
                if (inv_last) begin
                  lock_v_o  <= 1'b0;
                  slip_v_o  <= 1'b1;
                  lane_o    <= '0;
                  lane_id_o <= '0;
                  inv_cnt   <= '0;
                  state     <= ST_SLIP;
                end else begin
                  inv_cnt <= inv_cnt + 1'b1;
                  state   <= ST_COUNT_2;
                end
              end
            end
          end
          default: state <= ST_RESET_CNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_am_lock_multi_rx.sv
// Directed bench for am_lock_multi_rx: a 4-lane and a 20-lane instance, expected outputs queued per driven block.
module tb_am_lock_multi_rx;

  typedef struct {
    bit sel;
    bit e_lock;
    bit e_slip;
    bit e_am;
    bit e_bip;
    int e_lid;
  } exp_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        v4 = 1'b0, s4 = 1'b0, v20 = 1'b0, s20 = 1'b0;
  logic [65:0] b4 = '0, b20 = '0;
  logic        lk4, sl4, am4, be4, lk20, sl20, am20, be20;
  logic [3:0]  lane4;
  logic [1:0]  lid4;
  logic [19:0] lane20;
  logic [4:0]  lid20;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  bit   exp_lock = 1'b0;
  int   exp_lid = 0;
  logic [7:0] acc = '0;

  always #5 clk = ~clk;

  am_lock_multi_rx #(.BLOCK_W(66), .LANE_N(4), .GAP_N(16), .INVALID_MAX(4), .BIP_EN(1)) u4 (
    .clk(clk), .reset(reset), .valid_i(v4), .signal_v_i(s4), .block_i(b4),
    .lock_v_o(lk4), .slip_v_o(sl4), .am_v_o(am4), .lane_o(lane4), .lane_id_o(lid4), .bip_err_o(be4)
  );

  am_lock_multi_rx #(.BLOCK_W(66), .LANE_N(20), .GAP_N(16), .INVALID_MAX(4), .BIP_EN(1)) u20 (
    .clk(clk), .reset(reset), .valid_i(v20), .signal_v_i(s20), .block_i(b20),
    .lock_v_o(lk20), .slip_v_o(sl20), .am_v_o(am20), .lane_o(lane20), .lane_id_o(lid20), .bip_err_o(be20)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Marker values {M2,M1,M0} from the IEEE 40G / 100G tables, for the lanes exercised here.
  function automatic logic [23:0] m012(input bit n20, input int lane);
    if (n20) begin
      case (lane)
        0:       return 24'h2168C1;
        16:      return 24'h4C31C4;
        default: return 24'hB7D6AD;
      endcase
    end
    case (lane)
      0:       return 24'h477690;
      1:       return 24'hE6C4F0;
      2:       return 24'h9B65C5;
      default: return 24'h3D79A2;
    endcase
  endfunction

  function automatic logic [7:0] bip_of(input logic [65:0] b);
    logic [7:0]  r;
    logic [65:0] t;
    r = '0;
    t = b >> 2;
    for (int k = 0; k < 8; k++) begin
      r = r ^ t[7:0];
      t = t >> 8;
    end
    r = r ^ {3'b000, b[1], b[0], 3'b000};
    return r;
  endfunction

  function automatic logic [65:0] rnd_blk();
    logic [65:0] b;
    b[31:0]  = $urandom();
    b[63:32] = $urandom();
    b[65:64] = 2'($urandom());
    b[1:0]   = 2'b01;
    return b;
  endfunction

  task automatic step(input bit sel, input logic [65:0] blk, input bit vld, input bit sig,
                      input bit e_slip, input bit e_am, input bit e_bip);
    exp_t e;
    @(negedge clk);
    if (sel) begin
      b20 = blk; v20 = vld; s20 = sig; v4 = 1'b0; s4 = 1'b0;
    end else begin
      b4 = blk; v4 = vld; s4 = sig; v20 = 1'b0; s20 = 1'b0;
    end
    e.sel = sel; e.e_lock = exp_lock; e.e_slip = e_slip;
    e.e_am = e_am; e.e_bip = e_bip; e.e_lid = exp_lid;
    sb.push_back(e);
  endtask

  task automatic data1(input bit sel, input bit e_slip);
    logic [65:0] blk;
    blk = rnd_blk();
    step(sel, blk, 1'b1, 1'b1, e_slip, 1'b0, 1'b0);
    acc = acc ^ bip_of(blk);
  endtask

  task automatic data(input bit sel, input int n);
    repeat (n) data1(sel, 1'b0);
  endtask

  task automatic idle(input bit sel, input int n);
    repeat (n) step(sel, rnd_blk(), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic marker(input bit sel, input int lane, input bit as_data, input bit corrupt,
                        input bit e_slip, input bit e_am, input bit e_bip);
    logic [23:0] m;
    logic [7:0]  f;
    logic [65:0] blk;
    m   = m012(sel, lane);
    f   = corrupt ? (acc ^ 8'h5A) : acc;
    blk = {~f, ~m, f, m, 2'b10};
    step(sel, blk, 1'b1, 1'b1, e_slip, e_am, e_bip);
    if (as_data) acc = acc ^ bip_of(blk);
    else acc = bip_of(blk);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin : pop
      exp_t e;
      logic lk, sl, am, be;
      logic [31:0] ln, li;
      e = sb.pop_front();
      if (e.sel) begin
        lk = lk20; sl = sl20; am = am20; be = be20; ln = 32'(lane20); li = 32'(lid20);
      end else begin
        lk = lk4; sl = sl4; am = am4; be = be4; ln = 32'(lane4); li = 32'(lid4);
      end
      chk("lock", 32'(lk), 32'(e.e_lock));
      chk("slip", 32'(sl), 32'(e.e_slip));
      chk("am", 32'(am), 32'(e.e_am));
      chk("bip_err", 32'(be), 32'(e.e_bip));
      chk("lane_onehot", ln, e.e_lock ? (32'd1 << e.e_lid) : 32'd0);
      chk("lane_id", li, e.e_lock ? 32'(e.e_lid) : 32'd0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lock4", 32'(lk4), 0);   chk("rst_slip4", 32'(sl4), 0);
    chk("rst_am4", 32'(am4), 0);     chk("rst_bip4", 32'(be4), 0);
    chk("rst_lane4", 32'(lane4), 0); chk("rst_lid4", 32'(lid4), 0);
    chk("rst_lock20", 32'(lk20), 0); chk("rst_lane20", 32'(lane20), 0);
    chk("rst_lid20", 32'(lid20), 0); chk("rst_slip20", 32'(sl20), 0);
    @(negedge clk);
    reset = 1'b0;

    // 4-lane: acquire lane 2 with a 16-block gap.
    data(0, 4);
    marker(0, 2, 0, 0, 0, 0, 0);
    data(0, 16);
    exp_lock = 1'b1; exp_lid = 2;
    marker(0, 2, 0, 0, 0, 0, 0);

    // Valid gaps inside the count do not move the marker slot.
    data(0, 5); idle(0, 5); data(0, 11);
    marker(0, 2, 0, 0, 0, 1, 0);

    // A marker before the count completes is data.
    data(0, 10);
    marker(0, 2, 1, 0, 0, 0, 0);
    data(0, 5);
    marker(0, 2, 0, 0, 0, 1, 0);

    // Three bad slots then a good marker: lock holds.
    for (int i = 0; i < 3; i++) begin
      data(0, 16);
      data1(0, 1'b0);
    end
    data(0, 16);
    marker(0, 2, 0, 0, 0, 1, 0);

    // Four bad slots: slip on the fourth, lock drops in the same cycle.
    for (int i = 0; i < 4; i++) begin
      data(0, 16);
      if (i == 3) begin
        exp_lock = 1'b0; exp_lid = 0;
        data1(0, 1'b1);
      end else begin
        data1(0, 1'b0);
      end
    end
    data(0, 2);

    // First marker lane 1, second lane 2: slip without lock.
    marker(0, 1, 0, 0, 0, 0, 0);
    data(0, 16);
    marker(0, 2, 0, 0, 1, 0, 0);
    data(0, 2);

    // Lock lane 3, then drop signal_v_i, then reacquire on lane 0.
    marker(0, 3, 0, 0, 0, 0, 0);
    data(0, 16);
    exp_lock = 1'b1; exp_lid = 3;
    marker(0, 3, 0, 0, 0, 0, 0);
    data(0, 4);
    exp_lock = 1'b0; exp_lid = 0;
    step(0, rnd_blk(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    data(0, 1);
    marker(0, 0, 0, 0, 0, 0, 0);
    data(0, 16);
    exp_lock = 1'b1; exp_lid = 0;
    marker(0, 0, 0, 0, 0, 0, 0);
    data(0, 5);

    // Asynchronous reset mid-count clears outputs without a clock edge.
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_lock4", 32'(lk4), 0);
    chk("arst_lane4", 32'(lane4), 0);
    chk("arst_lid4", 32'(lid4), 0);
    exp_lock = 1'b0; exp_lid = 0;
    @(negedge clk);
    reset = 1'b0;

    // 20-lane: lock lane 17, corrupt BIP3 on the third marker.
    data(1, 1);
    marker(1, 17, 0, 0, 0, 0, 0);
    data(1, 16);
    exp_lock = 1'b1; exp_lid = 17;
    marker(1, 17, 0, 0, 0, 0, 0);
    data(1, 16);
    marker(1, 17, 0, 1, 0, 1, 1);
    data(1, 16);
    marker(1, 17, 0, 0, 0, 1, 0);
    data(1, 3);

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drain", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
